// File: rtl/aes_inv_round.sv
// Iterative AES inverse-cipher round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
// Define AES_INV_ROUND_PARALLEL_EN to substitute all four words in one cycle with four S-box instances.

package aes_inv_round_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse affine transform followed by the multiplicative inverse (a^254; 0 maps to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] a;
    logic [7:0] p;
    logic [7:0] r;
    a = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r) & 3) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
    end
    return o;
  endfunction

endpackage

module aes_sbox_inv (
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);
  import aes_inv_round_pkg::*;

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign data_o[8*b +: 8] = inv_sbox(data_i[8*b +: 8]);
  end
endmodule

module aes_inv_round (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         final_round,
  input  logic [127:0] block_in,
  input  logic [127:0] round_key,
  output logic         ready,
  output logic         out_valid,
  output logic [127:0] block_out
);
  import aes_inv_round_pkg::*;

  typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, FINISH = 2'd2} state_e;

  state_e         state_q, state_d;
  logic [127:0]   st_q, st_d;
  logic [127:0]   key_q, key_d;
  logic           fin_q, fin_d;
  logic [127:0]   bo_q, bo_d;
  logic           ov_q, ov_d;
  logic [127:0]   t_s;

`ifdef AES_INV_ROUND_PARALLEL_EN
  logic [127:0]   sub_all_s;

  for (genvar w = 0; w < 4; w++) begin : g_sbox
    aes_sbox_inv u_sbox (
      .data_i (st_q[127 - 32*w -: 32]),
      .data_o (sub_all_s[127 - 32*w -: 32])
    );
  end
`else
  logic [1:0]     cnt_q, cnt_d;
  logic [31:0]    sbox_in_s, sbox_out_s;

  // Word 0 is the most significant word of the state.
  assign sbox_in_s = st_q[127 - 32*int'(cnt_q) -: 32];

  aes_sbox_inv u_sbox (
    .data_i (sbox_in_s),
    .data_o (sbox_out_s)
  );
`endif

  assign t_s       = st_q ^ key_q;
  assign ready     = (state_q == IDLE);
  assign out_valid = ov_q;
  assign block_out = bo_q;

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    key_d   = key_q;
    fin_d   = fin_q;
    bo_d    = bo_q;
    ov_d    = 1'b0;
`ifndef AES_INV_ROUND_PARALLEL_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          st_d    = inv_shift_rows(block_in);
          key_d   = round_key;
          fin_d   = final_round;
`ifndef AES_INV_ROUND_PARALLEL_EN
          cnt_d   = 2'd0;
`endif
          state_d = SUB;
        end else begin
          state_d = IDLE;
        end
      end
      SUB: begin
`ifdef AES_INV_ROUND_PARALLEL_EN
        st_d    = sub_all_s;
        state_d = FINISH;
`else
        st_d[127 - 32*int'(cnt_q) -: 32] = sbox_out_s;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = FINISH;
        end else begin
          state_d = SUB;
        end
`endif
      end
      FINISH: begin
        bo_d    = fin_q ? t_s : inv_mix_columns(t_s);
        ov_d    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      st_q    <= 128'h0;
      key_q   <= 128'h0;
      fin_q   <= 1'b0;
      bo_q    <= 128'h0;
      ov_q    <= 1'b0;
`ifndef AES_INV_ROUND_PARALLEL_EN
      cnt_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      key_q   <= key_d;
      fin_q   <= fin_d;
      bo_q    <= bo_d;
      ov_q    <= ov_d;
`ifndef AES_INV_ROUND_PARALLEL_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_inv_round.sv
// Scoreboard bench for aes_inv_round: directed FIPS-197 vectors, held-start handshake, mid-round reset.

module tb_aes_inv_round;

`ifdef AES_INV_ROUND_PARALLEL_EN
  localparam int LAT       = 3;
  localparam int RST_EDGES = 1;
`else
  localparam int LAT       = 6;
  localparam int RST_EDGES = 3;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         final_round;
  logic [127:0] block_in;
  logic [127:0] round_key;
  logic         ready;
  logic         out_valid;
  logic [127:0] block_out;

  aes_inv_round dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .final_round (final_round),
    .block_in    (block_in),
    .round_key   (round_key),
    .ready       (ready),
    .out_valid   (out_valid),
    .block_out   (block_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    bit           ok;
    int           cyc;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  logic [127:0] exp_cur;
  bit           exp_ok = 1'b0;
  logic         prev_ov = 1'b0;

  logic [127:0] v_in  [4];
  logic [127:0] v_key [4];
  logic         v_fin [4];
  logic [127:0] v_exp [4];

  initial begin
    v_in[0] = 128'h0;  v_key[0] = 128'h0;  v_fin[0] = 1'b1;
    v_exp[0] = 128'h52525252525252525252525252525252;
    v_in[1] = 128'h0;  v_key[1] = 128'h0;  v_fin[1] = 1'b0;
    v_exp[1] = 128'h52525252525252525252525252525252;
    v_in[2] = 128'h6353e08c0960e104cd70b751bacad0e7;
    v_key[2] = 128'h000102030405060708090a0b0c0d0e0f;  v_fin[2] = 1'b1;
    v_exp[2] = 128'h00112233445566778899aabbccddeeff;
    v_in[3] = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    v_key[3] = 128'h549932d1f08557681093ed9cbe2c974e;  v_fin[3] = 1'b0;
    v_exp[3] = 128'h54d990a16ba09ab596bbf40ea111702f;
  end

  // Record each accept edge with the expected result the bench intended for it.
  always @(posedge clk) begin
    if (!reset && start && ready) begin
      sb_q.push_back('{d: exp_cur, ok: exp_ok, cyc: cyc});
    end
    cyc++;
  end

  // Monitor: pop and compare whenever the DUT presents a result.
  always @(negedge clk) begin
    if (out_valid) begin
      checks++;
      if (prev_ov) begin
        errors++;
        $display("FAIL out_valid_pulse: high on consecutive cycles, required single-cycle pulse");
      end
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: block_out=%h with no round pending", block_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (!e.ok) begin
          errors++;
          $display("FAIL ignored_start: a start outside IDLE was accepted, result %h", block_out);
        end else begin
          checks++;
          if (block_out !== e.d) begin
            errors++;
            $display("FAIL block_out: got %h required %h", block_out, e.d);
          end
          if (cyc - e.cyc != LAT) begin
            errors++;
            $display("FAIL latency: got %0d cycles required %0d", cyc - e.cyc, LAT);
          end
        end
      end
    end
    prev_ov = out_valid;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic garbage();
    block_in    = {$urandom, $urandom, $urandom, $urandom};
    round_key   = {$urandom, $urandom, $urandom, $urandom};
    final_round = 1'($urandom_range(0, 1));
  endtask

  task automatic set_vec(input int i);
    block_in    = v_in[i];
    round_key   = v_key[i];
    final_round = v_fin[i];
    exp_cur     = v_exp[i];
    exp_ok      = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d results still pending, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    exp_cur = 128'h0;
    garbage();
    #3;
    check("reset_ready", 128'(ready), 128'(1'b1));
    check("reset_out_valid", 128'(out_valid), 128'(1'b0));
    check("reset_block_out", block_out, 128'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single rounds with a one-cycle start pulse.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_vec(i);
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      exp_ok = 1'b0;
      #1;
      check("ready_low_after_accept", 128'(ready), 128'(1'b0));
      garbage();
      wait_idle();
    end

    // Start held high: only every LAT-th edge may accept; inputs churn in between.
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_vec((k + 2) % 4);
      @(negedge clk);
      exp_ok = 1'b0;
      for (int j = 0; j < LAT - 1; j++) begin
        garbage();
        @(negedge clk);
      end
    end

    // Accept one more, then reset partway through the round.
    set_vec(2);
    @(posedge clk);
    #1;
    exp_ok = 1'b0;
    garbage();
    repeat (RST_EDGES) @(posedge clk);
    #2;
    reset = 1'b1;
    sb_q.delete();
    #1;
    check("midreset_ready", 128'(ready), 128'(1'b1));
    check("midreset_out_valid", 128'(out_valid), 128'(1'b0));
    check("midreset_block_out", block_out, 128'h0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_vec(3);
    @(posedge clk);
    #1;
    check("accept_after_release", 128'(ready), 128'(1'b0));
    @(negedge clk);
    start  = 1'b0;
    exp_ok = 1'b0;
    garbage();
    wait_idle();

    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
